// File: rtl/taxi_axis_if.sv
// AXI4-Stream subset (tdata/tvalid/tready) carrying characters to the UART.
// Ports: tdata[DATA_W], tvalid (master->slave), tready (slave->master).
interface taxi_axis_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 5-8 data bits, optional parity, 1/1.5/2 stop, 8x baud.
// Ports: clk, rst (async active-low), s_axis_tx (slave), txd, busy,
//   data_bits, stop_bits, parity_en, parity_type, baud_clk.
// Option UART_TX_BREAK_EN adds break_req for line-break generation.
module uart_tx #(
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  taxi_axis_if.slave s_axis_tx,
  output logic       txd,
  output logic       busy,
  input  logic [1:0] data_bits,
  input  logic [1:0] stop_bits,
  input  logic       parity_en,
  input  logic       parity_type,
`ifdef UART_TX_BREAK_EN
  input  logic       break_req,
`endif
  input  logic       baud_clk
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
`ifdef UART_TX_BREAK_EN
    BREAK,
    BRK_END,
`endif
    STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic        r_rdy;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_n;
  logic [3:0]  w_cnt_adv;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_n;
  logic [7:0]  r_data;
  logic [1:0]  r_dbits;
  logic [1:0]  r_sbits;
  logic        r_pen;
  logic        r_ptype;
  logic        r_txd;
  logic        w_txd_n;
  logic        w_accept;
  logic        w_tick_end;
  logic        w_par;
  logic [3:0]  w_lim;
  logic [2:0]  w_last;
  logic [7:0]  w_mask;
  logic [DATA_W-1:0] w_tdata;

  assign w_tdata = s_axis_tx.tdata;

  // r_rdy keeps tready low through reset and until the first edge after.
`ifdef UART_TX_BREAK_EN
  assign s_axis_tx.tready = r_rdy && (r_state == IDLE) && !break_req;
`else
  assign s_axis_tx.tready = r_rdy && (r_state == IDLE);
`endif

  assign w_accept = s_axis_tx.tvalid && s_axis_tx.tready;
  assign w_last   = 3'd7 - {1'b0, r_dbits};

  always_comb begin
    w_mask = 8'hFF;
    unique case (r_dbits)
      2'b00: w_mask = 8'hFF;
      2'b01: w_mask = 8'h7F;
      2'b10: w_mask = 8'h3F;
      2'b11: w_mask = 8'h1F;
      default: w_mask = 8'hFF;
    endcase
  end

  // Parity covers only the bits that go on the wire.
  assign w_par = r_ptype ^ (^(r_data & w_mask));

  // Terminal tick count: 8 pulses per bit, stop stretched to 12 or 16.
  always_comb begin
    w_lim = 4'd7;
    if (r_state == STOP) begin
      unique case (1'b1)
        (r_sbits == 2'b01): w_lim = 4'd11;
        (r_sbits == 2'b10): w_lim = 4'd15;
        default:            w_lim = 4'd7;
      endcase
    end
  end

  assign w_tick_end = baud_clk && (r_cnt == w_lim);

  always_comb begin
    if (!baud_clk)
      w_cnt_adv = r_cnt;
    else if (w_tick_end)
      w_cnt_adv = 4'd0;
    else
      w_cnt_adv = r_cnt + 4'd1;
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = w_cnt_adv;
    w_bit_n   = r_bit;
    unique case (r_state)
      IDLE: begin
        w_cnt_n = 4'd0;
        w_bit_n = 3'd0;
        if (w_accept)
          w_state_n = START;
`ifdef UART_TX_BREAK_EN
        else if (break_req)
          w_state_n = BREAK;
`endif
      end
      START: begin
        if (w_tick_end)
          w_state_n = DATA;
      end
      DATA: begin
        if (w_tick_end) begin
          if (r_bit == w_last)
            w_state_n = r_pen ? PARITY : STOP;
          else
            w_bit_n = r_bit + 3'd1;
        end
      end
      PARITY: begin
        if (w_tick_end)
          w_state_n = STOP;
      end
      STOP: begin
        if (w_tick_end)
          w_state_n = IDLE;
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        w_cnt_n = 4'd0;
        if (!break_req)
          w_state_n = BRK_END;
      end
      BRK_END: begin
        if (w_tick_end)
          w_state_n = IDLE;
      end
`endif
      default: begin
        w_state_n = IDLE;
        w_cnt_n   = 4'd0;
      end
    endcase
  end

  // txd is loaded with the level of the state being entered.
  always_comb begin
    w_txd_n = 1'b1;
    unique case (w_state_n)
      START:   w_txd_n = 1'b0;
      DATA:    w_txd_n = r_data[w_bit_n];
      PARITY:  w_txd_n = w_par;
`ifdef UART_TX_BREAK_EN
      BREAK:   w_txd_n = 1'b0;
`endif
      default: w_txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
      r_cnt   <= 4'd0;
      r_bit   <= 3'd0;
      r_data  <= 8'd0;
      r_dbits <= 2'd0;
      r_sbits <= 2'd0;
      r_pen   <= 1'b0;
      r_ptype <= 1'b0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_rdy   <= 1'b1;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_txd   <= w_txd_n;
      if (w_accept) begin
        r_data  <= w_tdata[7:0];
        r_dbits <= data_bits;
        r_sbits <= stop_bits;
        r_pen   <= parity_en;
        r_ptype <= parity_type;
      end
    end
  end

  assign txd  = r_txd;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx.
// Decodes txd bit by bit against the baud pulse count.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_clk = 1'b0;
  logic [1:0] bdiv = 2'd0;
  logic [1:0] data_bits = 2'b00;
  logic [1:0] stop_bits = 2'b00;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic       txd;
  logic       busy;
  int         vectors = 0;
  int         miscompares = 0;

  taxi_axis_if #(.DATA_W(8)) axis ();

  uart_tx #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_axis_tx   (axis),
    .txd         (txd),
    .busy        (busy),
    .data_bits   (data_bits),
    .stop_bits   (stop_bits),
    .parity_en   (parity_en),
    .parity_type (parity_type),
`ifdef UART_TX_BREAK_EN
    .break_req   (1'b0),
`endif
    .baud_clk    (baud_clk)
  );

  always #5 clk = ~clk;

  // One baud_clk pulse every 4 clocks.
  always @(posedge clk) begin
    bdiv     <= bdiv + 2'd1;
    baud_clk <= (bdiv == 2'd3);
  end

  task automatic send_start(input logic [7:0] d, input bit keep,
                            output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    axis.tdata  = d;
    axis.tvalid = 1'b1;
    while (!axis.tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = axis.tready;
    @(posedge clk);
    #1;
    if (!keep) axis.tvalid = 1'b0;
  endtask

  // Records the first level of each bit and flags anything odd in a bit.
  task automatic capture(input int nbits, input int last_dur,
                         output logic [15:0] obs, output bit glitch,
                         output bit rdy_seen, output bit busy_low);
    int pulses;
    int guard;
    bit first;
    int d;
    obs = '0;
    glitch = 0;
    rdy_seen = 0;
    busy_low = 0;
    guard = 0;
    for (int i = 0; i < nbits; i++) begin
      d = (i == nbits - 1) ? last_dur : 8;
      pulses = 0;
      first = 1;
      while (pulses < d && guard < 4000) begin
        @(negedge clk);
        guard++;
        if (first) obs[i] = txd;
        else if (txd !== obs[i]) glitch = 1;
        first = 0;
        if (axis.tready) rdy_seen = 1;
        if (busy !== 1'b1) busy_low = 1;
        if (baud_clk) pulses++;
      end
    end
    if (guard >= 4000) glitch = 1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (txd !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_txd: got %b want 1", txd);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    vectors++;
    if (axis.tready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tready: got %b want 0", axis.tready);
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (axis.tready !== 1'b0) begin
      miscompares++;
      $display("FAIL release_tready_early: got %b want 0", axis.tready);
    end
    @(negedge clk);
    vectors++;
    if (axis.tready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_tready: got %b want 1", axis.tready);
    end
  endtask

  task automatic test_8n1;
    bit ok, gl, rs, bl;
    logic [15:0] obs;
    logic [9:0] exp;
    exp = {1'b1, 8'hA5, 1'b0};
    data_bits = 2'b00; stop_bits = 2'b00;
    parity_en = 1'b0; parity_type = 1'b0;
    send_start(8'hA5, 0, ok);
    capture(10, 8, obs, gl, rs, bl);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL 8n1_accept: tready never seen");
    end
    vectors++;
    if (obs[9:0] !== exp) begin
      miscompares++;
      $display("FAIL 8n1_frame: got %b want %b", obs[9:0], exp);
    end
    vectors++;
    if ({gl, rs, bl} !== 3'b000) begin
      miscompares++;
      $display("FAIL 8n1_stable: glitch/rdy/busylow %b want 000",
               {gl, rs, bl});
    end
    @(negedge clk);
    vectors++;
    if ({busy, axis.tready, txd} !== 3'b011) begin
      miscompares++;
      $display("FAIL 8n1_idle: busy/tready/txd %b want 011",
               {busy, axis.tready, txd});
    end
  endtask

  task automatic test_7e1;
    bit ok, gl, rs, bl;
    logic [15:0] obs;
    logic [9:0] exp;
    exp = {1'b1, 1'b0, 7'h5A, 1'b0};
    data_bits = 2'b01; stop_bits = 2'b00;
    parity_en = 1'b1; parity_type = 1'b0;
    send_start(8'h5A, 0, ok);
    capture(10, 8, obs, gl, rs, bl);
    vectors++;
    if (!ok || obs[9:0] !== exp) begin
      miscompares++;
      $display("FAIL 7e1_frame: got %b want %b ok=%0d", obs[9:0], exp, ok);
    end
    vectors++;
    if ({gl, rs, bl} !== 3'b000) begin
      miscompares++;
      $display("FAIL 7e1_stable: glitch/rdy/busylow %b want 000",
               {gl, rs, bl});
    end
    @(negedge clk);
    vectors++;
    if ({busy, axis.tready} !== 2'b01) begin
      miscompares++;
      $display("FAIL 7e1_idle: busy/tready %b want 01", {busy, axis.tready});
    end
  endtask

  task automatic test_5o2;
    bit ok, gl, rs, bl;
    logic [15:0] obs;
    logic [7:0] exp;
    exp = {1'b1, 1'b0, 5'h1F, 1'b0};
    data_bits = 2'b11; stop_bits = 2'b10;
    parity_en = 1'b1; parity_type = 1'b1;
    send_start(8'h1F, 0, ok);
    capture(8, 16, obs, gl, rs, bl);
    vectors++;
    if (!ok || obs[7:0] !== exp) begin
      miscompares++;
      $display("FAIL 5o2_frame: got %b want %b ok=%0d", obs[7:0], exp, ok);
    end
    vectors++;
    if ({gl, rs, bl} !== 3'b000) begin
      miscompares++;
      $display("FAIL 5o2_stop16: glitch/rdy/busylow %b want 000",
               {gl, rs, bl});
    end
    @(negedge clk);
    vectors++;
    if ({busy, axis.tready} !== 2'b01) begin
      miscompares++;
      $display("FAIL 5o2_idle: busy/tready %b want 01", {busy, axis.tready});
    end
  endtask

  task automatic test_stop_1p5;
    bit ok, gl, rs, bl;
    logic [15:0] obs;
    logic [8:0] exp;
    exp = {1'b1, 1'b0, 6'h2B, 1'b0};
    data_bits = 2'b10; stop_bits = 2'b01;
    parity_en = 1'b1; parity_type = 1'b0;
    send_start(8'h2B, 0, ok);
    capture(9, 12, obs, gl, rs, bl);
    vectors++;
    if (!ok || obs[8:0] !== exp) begin
      miscompares++;
      $display("FAIL 6e15_frame: got %b want %b ok=%0d", obs[8:0], exp, ok);
    end
    vectors++;
    if ({gl, rs, bl} !== 3'b000) begin
      miscompares++;
      $display("FAIL 6e15_stop12: glitch/rdy/busylow %b want 000",
               {gl, rs, bl});
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL 6e15_idle: busy %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    bit ok, gl, rs, bl;
    logic [15:0] obs;
    logic [9:0] exp1, exp2;
    exp1 = {1'b1, 8'h11, 1'b0};
    exp2 = {1'b1, 8'h22, 1'b0};
    data_bits = 2'b00; stop_bits = 2'b00;
    parity_en = 1'b0; parity_type = 1'b0;
    send_start(8'h11, 1, ok);
    axis.tdata = 8'h22;
    capture(10, 8, obs, gl, rs, bl);
    vectors++;
    if (!ok || obs[9:0] !== exp1 || gl) begin
      miscompares++;
      $display("FAIL b2b_first: got %b want %b", obs[9:0], exp1);
    end
    @(negedge clk);
    vectors++;
    if ({axis.tready, txd} !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_gap: tready/txd %b want 11", {axis.tready, txd});
    end
    @(posedge clk);
    #1 axis.tvalid = 1'b0;
    capture(10, 8, obs, gl, rs, bl);
    vectors++;
    if (obs[9:0] !== exp2 || gl) begin
      miscompares++;
      $display("FAIL b2b_second: got %b want %b", obs[9:0], exp2);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: busy %b want 0", busy);
    end
  endtask

  task automatic test_cfg_change;
    bit ok, gl, rs, bl;
    logic [15:0] obs;
    logic [9:0] exp;
    exp = {1'b1, 8'hC3, 1'b0};
    data_bits = 2'b00; stop_bits = 2'b00;
    parity_en = 1'b0; parity_type = 1'b0;
    send_start(8'hC3, 0, ok);
    fork
      capture(10, 8, obs, gl, rs, bl);
      begin
        repeat (60) @(negedge clk);
        data_bits = 2'b11;
        parity_en = 1'b1;
      end
    join
    vectors++;
    if (!ok || obs[9:0] !== exp || gl || bl) begin
      miscompares++;
      $display("FAIL cfg_change: got %b want %b", obs[9:0], exp);
    end
    @(negedge clk);
    data_bits = 2'b00;
    parity_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok, gl, rs, bl;
    logic [15:0] obs;
    logic [9:0] exp;
    int pulses;
    int guard;
    exp = {1'b1, 8'h3C, 1'b0};
    send_start(8'h3C, 0, ok);
    pulses = 0;
    guard = 0;
    while (pulses < 34 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (baud_clk) pulses++;
    end
    vectors++;
    if (busy !== 1'b1 || guard >= 1000) begin
      miscompares++;
      $display("FAIL rstmid_busy_before: got %b want 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({txd, busy, axis.tready} !== 3'b100) begin
      miscompares++;
      $display("FAIL rstmid_async: txd/busy/tready %b want 100",
               {txd, busy, axis.tready});
    end
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, axis.tready, txd} !== 3'b011) begin
      miscompares++;
      $display("FAIL rstmid_release: busy/tready/txd %b want 011",
               {busy, axis.tready, txd});
    end
    send_start(8'h3C, 0, ok);
    capture(10, 8, obs, gl, rs, bl);
    vectors++;
    if (!ok || obs[9:0] !== exp || gl) begin
      miscompares++;
      $display("FAIL rstmid_next: got %b want %b", obs[9:0], exp);
    end
  endtask

  initial begin
    axis.tdata  = 8'h00;
    axis.tvalid = 1'b0;
    test_reset();
    test_8n1();
    test_7e1();
    test_5o2();
    test_stop_1p5();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
